// File: rtl/fir_out_decimator.sv
// Decimates a filter output stream (keeps 1 of every dec_ratio+1 valid samples)
// and buffers the kept samples in a small first-word fall-through FIFO.
module fir_out_decimator #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] Data_in,
  input  logic              in_en,
  input  logic [2:0]        dec_ratio,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        fill,
  output logic              overflow,
  input  logic              clear_ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [2:0]        r_phase;
  logic [2:0]        r_ratioPrev;
  logic [AW-1:0]     r_wrPtr;
  logic [AW-1:0]     r_rdPtr;
  logic [AW:0]       r_count;
  logic              r_overflow;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic       w_keep;
  logic       w_pop;
  logic       w_full;
  logic       w_push;
  logic       w_drop;
  logic       w_ratioChg;
  logic [2:0] w_phaseNext;

  assign w_keep     = in_en && (r_phase == 3'd0);
  assign w_full     = (r_count == FULL_CNT);
  assign w_pop      = (r_count != '0) && out_ready;
  assign w_push     = w_keep && (!w_full || w_pop);
  assign w_drop     = w_keep && w_full && !w_pop;
  assign w_ratioChg = (dec_ratio != r_ratioPrev);

  // A ratio change that leaves the phase at or beyond the new ratio restarts decimation.
  always_comb begin
    w_phaseNext = r_phase;
    if (w_ratioChg && (r_phase >= dec_ratio)) begin
      w_phaseNext = 3'd0;
    end else if (in_en) begin
      w_phaseNext = (r_phase >= dec_ratio) ? 3'd0 : r_phase + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase     <= 3'd0;
      r_ratioPrev <= 3'd0;
    end else begin
      r_phase     <= w_phaseNext;
      r_ratioPrev <= dec_ratio;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clear_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Storage needs no reset: entries are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= Data_in;
    end
  end

  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rdPtr];
  assign fill      = 3'(r_count);
  assign overflow  = r_overflow;

endmodule
